// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - EX/MEM request, data-cache and MEM/WB signal bundle for mem_stage_ctrl
interface mem_stage_ctrl_if #(
  parameter int AW = 32
);
  logic          ex_valid;
  logic          ex_MemRead;
  logic          ex_MemWrite;
  logic [AW-1:0] ex_addr;
  logic [AW-1:0] ex_store;
  logic          ex_RegWrite;
  logic          ex_MemToReg;
  logic          ex_LL;
  logic          ex_SC;
  logic          flush;
  logic          dhit;
  logic [AW-1:0] dmemload;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [AW-1:0] dmemstore;
  logic          stall_out;
  logic          mwb_wen;
  logic [AW-1:0] mwb_dmemload;
  logic [AW-1:0] mwb_dmemaddr;
  logic          mwb_RegWrite;
  logic          mwb_MemToReg;
  logic          err_timeout;
  logic          err_misalign;

  modport slave (
    input  ex_valid, ex_MemRead, ex_MemWrite, ex_addr, ex_store, ex_RegWrite,
           ex_MemToReg, ex_LL, ex_SC, flush, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, stall_out, mwb_wen,
           mwb_dmemload, mwb_dmemaddr, mwb_RegWrite, mwb_MemToReg,
           err_timeout, err_misalign
  );

  modport master (
    output ex_valid, ex_MemRead, ex_MemWrite, ex_addr, ex_store, ex_RegWrite,
           ex_MemToReg, ex_LL, ex_SC, flush, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall_out, mwb_wen,
           mwb_dmemload, mwb_dmemaddr, mwb_RegWrite, mwb_MemToReg,
           err_timeout, err_misalign
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: drives the data cache until dhit and stalls the pipeline
// Optional load-linked/store-conditional link register enabled by defining LLSC_EN.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32
) (
  input logic              CLK,
  input logic              nRST,
  mem_stage_ctrl_if.slave  bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q, state_d;
  logic          ren_q, ren_d, wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d, store_q, store_d;
  logic          rw_q, rw_d, m2r_q, m2r_d, sc_q, sc_d, fp_q, fp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic          mem_op, misalign, sc_ok;
  logic          stall, mwb_wen, mwb_rw, mwb_m2r, mis;
  logic [AW-1:0] mwb_load, mwb_addr;

  assign mem_op   = bus.ex_valid & (bus.ex_MemRead | bus.ex_MemWrite);
  assign misalign = |bus.ex_addr[1:0];

`ifdef LLSC_EN
  logic          link_v_q, link_v_d, ll_q, ll_d;
  logic [AW-1:0] link_a_q, link_a_d;
  assign sc_ok = ~bus.ex_SC | (link_v_q & (link_a_q == bus.ex_addr));
`else
  logic unused_ll;
  assign unused_ll = bus.ex_LL;
  assign sc_ok     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    rw_d     = rw_q;
    m2r_d    = m2r_q;
    sc_d     = sc_q;
    fp_d     = fp_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
`ifdef LLSC_EN
    link_v_d = link_v_q;
    link_a_d = link_a_q;
    ll_d     = ll_q;
`endif
    stall    = 1'b0;
    mwb_wen  = 1'b1;
    mwb_load = '0;
    mwb_addr = bus.ex_addr;
    mwb_rw   = 1'b0;
    mwb_m2r  = bus.ex_MemToReg;
    mis      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          mwb_rw = bus.ex_valid & bus.ex_RegWrite & ~bus.flush;
        end else if (misalign) begin
          mis = 1'b1;
        end else if (bus.flush) begin
          mwb_rw = 1'b0;
        end else if (!sc_ok) begin
          // Failed store-conditional completes at once with result 0.
          mwb_rw = bus.ex_RegWrite;
        end else begin
          ren_d   = bus.ex_MemRead;
          wen_d   = bus.ex_MemWrite;
          addr_d  = bus.ex_addr;
          store_d = bus.ex_store;
          rw_d    = bus.ex_RegWrite;
          m2r_d   = bus.ex_MemToReg;
          sc_d    = bus.ex_SC & bus.ex_MemWrite;
`ifdef LLSC_EN
          ll_d    = bus.ex_LL;
`endif
          fp_d    = 1'b0;
          cnt_d   = '0;
          stall   = 1'b1;
          mwb_wen = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        mwb_addr = addr_q;
        mwb_m2r  = m2r_q;
        stall    = ~bus.dhit;
        mwb_wen  = 1'b0;
        cnt_d    = cnt_q + CW'(1);
        if (bus.flush) fp_d = 1'b1;
        if (bus.dhit) begin
          mwb_wen  = 1'b1;
          mwb_load = wen_q ? {{(AW-1){1'b0}}, sc_q} : bus.dmemload;
          mwb_rw   = rw_q & ~fp_q & ~bus.flush;
`ifdef LLSC_EN
          if (ll_q && ren_q && !fp_q && !bus.flush) begin
            link_v_d = 1'b1;
            link_a_d = addr_q;
          end
          if (wen_q && (link_a_q == addr_q)) link_v_d = 1'b0;
`endif
          ren_d    = 1'b0;
          wen_d    = 1'b0;
          fp_d     = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          tmo_d    = 1'b1;
          stall    = 1'b0;
          mwb_wen  = 1'b1;
          ren_d    = 1'b0;
          wen_d    = 1'b0;
          fp_d     = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      rw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      sc_q     <= 1'b0;
      fp_q     <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`ifdef LLSC_EN
      link_v_q <= 1'b0;
      link_a_q <= '0;
      ll_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      rw_q     <= rw_d;
      m2r_q    <= m2r_d;
      sc_q     <= sc_d;
      fp_q     <= fp_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`ifdef LLSC_EN
      link_v_q <= link_v_d;
      link_a_q <= link_a_d;
      ll_q     <= ll_d;
`endif
    end
  end

  assign bus.dmemREN      = ren_q;
  assign bus.dmemWEN      = wen_q;
  assign bus.dmemaddr     = addr_q;
  assign bus.dmemstore    = store_q;
  assign bus.stall_out    = stall;
  assign bus.mwb_wen      = mwb_wen;
  assign bus.mwb_dmemload = mwb_load;
  assign bus.mwb_dmemaddr = mwb_addr;
  assign bus.mwb_RegWrite = mwb_rw;
  assign bus.mwb_MemToReg = mwb_m2r;
  assign bus.err_timeout  = tmo_q;
  assign bus.err_misalign = mis;
endmodule
